// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, handles hazard freeze and taken-branch redirect, keeps debug counters.
module if_stage_pipe #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hazard_detected,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_addr,
    input  logic [INSTR_WIDTH-1:0] instr_rdata,
    input  logic                   cnt_clear,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    output logic [ADDR_WIDTH-1:0]  if_id_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic                   if_id_valid,
    output logic [CNT_WIDTH-1:0]   stall_count,
    output logic [CNT_WIDTH-1:0]   flush_count
);

    typedef enum logic [1:0] {
        MODE_ADVANCE  = 2'd0,
        MODE_FREEZE   = 2'd1,
        MODE_REDIRECT = 2'd2
    } mode_e;

    mode_e                  mode;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_plus4;

    // Redirect wins over freeze: a taken branch squashes whatever the hazard was holding.
    always_comb begin
        mode = MODE_ADVANCE;
        if (branch_taken) begin
            mode = MODE_REDIRECT;
        end else if (hazard_detected) begin
            mode = MODE_FREEZE;
        end
    end

    assign pc_plus4   = pc + ADDR_WIDTH'(4);
    assign instr_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else begin
            unique case (mode)
                MODE_REDIRECT: begin
                    pc          <= branch_addr;
                    if_id_pc    <= '0;
                    if_id_instr <= '0;
                    if_id_valid <= 1'b0;
                end
                MODE_FREEZE: begin
                    pc          <= pc;
                    if_id_pc    <= if_id_pc;
                    if_id_instr <= if_id_instr;
                    if_id_valid <= if_id_valid;
                end
                default: begin
                    pc          <= pc_plus4;
                    if_id_pc    <= pc_plus4;
                    if_id_instr <= instr_rdata;
                    if_id_valid <= 1'b1;
                end
            endcase
        end
    end

    // Saturating counters; clear overrides a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (cnt_clear) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (mode == MODE_FREEZE && stall_count != '1) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
            if (mode == MODE_REDIRECT && flush_count != '1) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
